// File: rtl/pll_lock_reset_seq.sv
// Reset sequencer for the pixel-clock domain. It synchronises the PLL lock, waits for a stable
// lock, releases the video reset and then the core reset, and counts lock losses for debug.
module pll_lock_reset_seq #(
  parameter int SYNC_STAGES    = 2,
  parameter int LOCK_CYCLES    = 4096,
  parameter int STAGGER_CYCLES = 16,
  parameter int LOSS_CNT_W     = 8
) (
  input  logic                  clk_pix,
  input  logic                  rst,
  input  logic                  locked,
  output logic                  rst_video,
  output logic                  rst_core,
  output logic                  ready,
  output logic                  lock_lost,
  output logic [LOSS_CNT_W-1:0] lock_loss_count
);

  localparam int MAX_CYCLES = (LOCK_CYCLES > STAGGER_CYCLES) ? LOCK_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    SETTLE,
    REL_VIDEO,
    RUN
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  state_t                 state;
  logic [CNT_W-1:0]       cnt;

  // NOTE: the synchroniser flops are cleared on reset. This keeps lock_s low until a
  // fresh lock has passed through the whole chain, so a restart never sees stale lock.
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // NOTE: state and outputs update with non-blocking assignments, so every branch below
  // reads the values from before this edge.
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      state           <= WAIT_LOCK;
      cnt             <= '0;
      rst_video       <= 1'b1;
      rst_core        <= 1'b1;
      ready           <= 1'b0;
      lock_lost       <= 1'b0;
      lock_loss_count <= '0;
    end else begin
      lock_lost <= 1'b0;
      case (state)
        WAIT_LOCK: begin
          if (lock_s) begin
            state <= SETTLE;
            cnt   <= '0;
          end
        end
        SETTLE: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
          end else if (cnt == LOCK_LAST) begin
            state     <= REL_VIDEO;
            cnt       <= '0;
            rst_video <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        REL_VIDEO, RUN: begin
          // A loss takes priority over the stagger expiry, so rst_core cannot release on the same edge.
          if (!lock_s) begin
            state     <= WAIT_LOCK;
            rst_video <= 1'b1;
            rst_core  <= 1'b1;
            ready     <= 1'b0;
            lock_lost <= 1'b1;
            if (lock_loss_count != '1) begin
              lock_loss_count <= lock_loss_count + LOSS_CNT_W'(1);
            end
          end else if (state == REL_VIDEO) begin
            if (cnt == STAGGER_LAST) begin
              state    <= RUN;
              rst_core <= 1'b0;
              ready    <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: state <= WAIT_LOCK;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Self-checking bench for pll_lock_reset_seq. It applies table vectors and hand-written corner
// sequences, then randomised lock patterns compared against a lock-run-length reference model.
module tb_pll_lock_reset_seq;

  localparam int SYNC    = 2;
  localparam int LOCK    = 8;
  localparam int STAG    = 4;
  localparam int CW      = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk_pix = 1'b0;
  logic          rst;
  logic          locked;
  logic          rst_video;
  logic          rst_core;
  logic          ready;
  logic          lock_lost;
  logic [CW-1:0] lock_loss_count;

  int n_checks = 0;
  int n_pass   = 0;

  // The reference model tracks how many consecutive edges have seen synchronised lock.
  logic pipe [SYNC];
  int   m_run  = 0;
  logic m_lost = 1'b0;
  int   m_cnt  = 0;

  typedef struct {
    logic rst;
    logic locked;
    int   n;
    logic v;
    logic c;
    logic rdy;
    logic lost;
    int   cnt;
  } vec_t;

  vec_t tbl[$];

  pll_lock_reset_seq #(
    .SYNC_STAGES   (SYNC),
    .LOCK_CYCLES   (LOCK),
    .STAGGER_CYCLES(STAG),
    .LOSS_CNT_W    (CW)
  ) dut (
    .clk_pix        (clk_pix),
    .rst            (rst),
    .locked         (locked),
    .rst_video      (rst_video),
    .rst_core       (rst_core),
    .ready          (ready),
    .lock_lost      (lock_lost),
    .lock_loss_count(lock_loss_count)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, req);
  endtask

  task automatic check_outs(input string tag, input logic v, input logic c, input logic r,
                            input logic l, input int cnt);
    check({tag, " rst_video"}, 32'(rst_video), 32'(v));
    check({tag, " rst_core"}, 32'(rst_core), 32'(c));
    check({tag, " ready"}, 32'(ready), 32'(r));
    check({tag, " lock_lost"}, 32'(lock_lost), 32'(l));
    check({tag, " count"}, 32'(lock_loss_count), cnt);
  endtask

  task automatic model_update();
    logic l;
    logic was_released;
    if (rst) begin
      for (int i = 0; i < SYNC; i++) pipe[i] = 1'b0;
      m_run  = 0;
      m_lost = 1'b0;
      m_cnt  = 0;
    end else begin
      l = pipe[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0]      = locked;
      was_released = (m_run >= LOCK + 1);
      if (l) m_run = (m_run < 1000000) ? m_run + 1 : m_run;
      else   m_run = 0;
      m_lost = !l && was_released;
      if (m_lost && m_cnt < CNT_MAX) m_cnt++;
    end
  endtask

  task automatic step();
    @(posedge clk_pix);
    #1;
    model_update();
  endtask

  task automatic check_model(input string tag);
    check_outs(tag, m_run < LOCK + 1, m_run < LOCK + STAG + 1, m_run >= LOCK + STAG + 1,
               m_lost, m_cnt);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    locked = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic lose_once();
    locked = 1'b1;
    repeat (LOCK + STAG + 3) step();
    locked = 1'b0;
    repeat (SYNC + 2) step();
  endtask

  initial begin
    for (int i = 0; i < SYNC; i++) pipe[i] = 1'b0;
    rst    = 1'b1;
    locked = 1'b0;

    // Lock at edge 0, release at 10/14, loss sampled at 20 and seen at 22, then relock.
    tbl.push_back('{1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b0, 1'b1, 10, 1'b1, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b0, 1'b1, 4, 1'b0, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b0, 1'b1, 6, 1'b0, 1'b0, 1'b1, 1'b0, 0});
    tbl.push_back('{1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b1, 1'b0, 0});
    tbl.push_back('{1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b1, 1});
    tbl.push_back('{1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1});
    tbl.push_back('{1'b0, 1'b1, 10, 1'b1, 1'b1, 1'b0, 1'b0, 1});
    tbl.push_back('{1'b0, 1'b1, 4, 1'b0, 1'b1, 1'b0, 1'b0, 1});
    tbl.push_back('{1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1});

    foreach (tbl[i]) begin
      rst    = tbl[i].rst;
      locked = tbl[i].locked;
      for (int k = 0; k < tbl[i].n; k++) begin
        step();
        check_outs($sformatf("vec%0d.%0d", i, k), tbl[i].v, tbl[i].c, tbl[i].rdy,
                   tbl[i].lost, tbl[i].cnt);
      end
    end

    // A three-cycle glitch during SETTLE restarts the full wait without counting a loss.
    do_reset();
    locked = 1'b1;
    repeat (5) step();
    locked = 1'b0;
    repeat (3) begin
      step();
      check("glitch lock_lost low", 32'(lock_lost), 0);
    end
    locked = 1'b1;
    for (int k = 0; k < LOCK + SYNC; k++) begin
      step();
      check($sformatf("glitch rst_video held %0d", k), 32'(rst_video), 1);
      check($sformatf("glitch lock_lost %0d", k), 32'(lock_lost), 0);
      check($sformatf("glitch count %0d", k), 32'(lock_loss_count), 0);
    end
    step();
    check("glitch rst_video released", 32'(rst_video), 0);

    // The lock-loss counter saturates at 3 while every loss still pulses lock_lost.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      locked = 1'b1;
      repeat (LOCK + STAG + 3) step();
      check($sformatf("sat%0d ready", i), 32'(ready), 1);
      locked = 1'b0;
      step();
      step();
      check($sformatf("sat%0d no early pulse", i), 32'(lock_lost), 0);
      step();
      check($sformatf("sat%0d pulse", i), 32'(lock_lost), 1);
      check($sformatf("sat%0d count", i), 32'(lock_loss_count), (i + 1 > 3) ? 3 : i + 1);
      step();
      check($sformatf("sat%0d pulse ends", i), 32'(lock_lost), 0);
    end

    // A one-cycle rst while in RUN with count 2 clears everything and restarts the sequence.
    do_reset();
    lose_once();
    lose_once();
    locked = 1'b1;
    repeat (LOCK + STAG + 3) step();
    check("pre-rst ready", 32'(ready), 1);
    check("pre-rst count", 32'(lock_loss_count), 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_outs("rst in run", 1'b1, 1'b1, 1'b0, 1'b0, 0);
    for (int k = 0; k < LOCK + SYNC; k++) begin
      step();
      check($sformatf("post-rst rst_video held %0d", k), 32'(rst_video), 1);
    end
    step();
    check("post-rst rst_video released", 32'(rst_video), 0);
    repeat (STAG) step();
    check("post-rst ready", 32'(ready), 1);

    // rst on the same edge as a loss wins: no pulse, and the count clears.
    lose_once();
    locked = 1'b1;
    repeat (LOCK + STAG + 3) step();
    check("rst+loss pre count", 32'(lock_loss_count), 1);
    locked = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_outs("rst+loss", 1'b1, 1'b1, 1'b0, 1'b0, 0);

    // Lock drops so that lock_s is low on the terminal REL_VIDEO cycle, and rst_core never releases.
    do_reset();
    locked = 1'b1;
    for (int k = 0; k < LOCK + SYNC + 2; k++) begin
      step();
      check($sformatf("term rst_core %0d", k), 32'(rst_core), 1);
    end
    check("term rst_video released", 32'(rst_video), 0);
    locked = 1'b0;
    step();
    step();
    check("term rst_video still low", 32'(rst_video), 0);
    check("term rst_core still high", 32'(rst_core), 1);
    step();
    check_outs("term loss", 1'b1, 1'b1, 1'b0, 1'b1, 1);
    repeat (4) begin
      step();
      check("term rst_core after", 32'(rst_core), 1);
    end

    // Randomised lock patterns with occasional resets, compared against the reference model.
    do_reset();
    for (int seg = 0; seg < 250; seg++) begin
      int len;
      rst    = ($urandom_range(0, 39) == 0);
      locked = $urandom_range(0, 2) != 0;
      len    = locked ? $urandom_range(3, 30) : $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        step();
        check_model($sformatf("rand%0d.%0d", seg, k));
        rst = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
